// File: rtl/sklansky_adder.sv
// Registered unsigned adder {c_out,S} = A + B + c_in with carries from a Sklansky parallel-prefix tree.
// Define SKLANSKY_ADDER_INPUT_REG_EN to register the operands ahead of the tree (latency 2 instead of 1).
module sklansky_adder #(
   parameter int INPUT_SIZE = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [INPUT_SIZE-1:0] A,
   input  logic [INPUT_SIZE-1:0] B,
   input  logic                  c_in,
   input  logic                  valid_in,
   output logic [INPUT_SIZE-1:0] S,
   output logic                  c_out,
   output logic                  valid_out
);

   localparam int N      = INPUT_SIZE;
   localparam int LEVELS = $clog2(N + 1);
   localparam int IDX_W  = $clog2(N + 1);

   // Prefix positions are shifted up by one: position 0 carries c_in (bit -1), position i+1 is bit i.
   // After the last level, position j holds the group generate over bits j-1 down to -1.
   function automatic logic [N:0] sklansky_prefix(input logic [N:0] g_in, input logic [N:0] p_in);
      logic [N:0]       g_cur, p_cur, g_nxt, p_nxt;
      logic [IDX_W-1:0] hi_i, lo_i;
      g_cur = g_in;
      p_cur = p_in;
      for (int k = 0; k < LEVELS; k++) begin
         g_nxt = g_cur;
         p_nxt = p_cur;
         for (int j = 0; j <= N; j++) begin
            if (((j >> k) & 1) != 0) begin
               hi_i = IDX_W'(j);
               lo_i = IDX_W'(((j >> k) << k) - 1);
               g_nxt[hi_i] = g_cur[hi_i] | (p_cur[hi_i] & g_cur[lo_i]);
               p_nxt[hi_i] = p_cur[hi_i] & p_cur[lo_i];
            end
         end
         g_cur = g_nxt;
         p_cur = p_nxt;
      end
      return g_cur;
   endfunction

   logic [N-1:0] a_op, b_op;
   logic         cin_op, vld_op;

   // ---- stage p0: optional operand registers ----
`ifdef SKLANSKY_ADDER_INPUT_REG_EN
   logic [N-1:0] a_p0_d, a_p0_q, b_p0_d, b_p0_q;
   logic         cin_p0_d, cin_p0_q, vld_p0_d, vld_p0_q;

   always_comb begin
      a_p0_d   = A;
      b_p0_d   = B;
      cin_p0_d = c_in;
      vld_p0_d = valid_in;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_p0_q   <= '0;
         b_p0_q   <= '0;
         cin_p0_q <= 1'b0;
         vld_p0_q <= 1'b0;
      end else begin
         a_p0_q   <= a_p0_d;
         b_p0_q   <= b_p0_d;
         cin_p0_q <= cin_p0_d;
         vld_p0_q <= vld_p0_d;
      end
   end

   assign a_op   = a_p0_q;
   assign b_op   = b_p0_q;
   assign cin_op = cin_p0_q;
   assign vld_op = vld_p0_q;
`else
   assign a_op   = A;
   assign b_op   = B;
   assign cin_op = c_in;
   assign vld_op = valid_in;
`endif

   // ---- stage p1: prefix network and sum, registered at the output ----
   logic [N-1:0] g_bit, p_bit, s_p1_d, s_p1_q;
   logic [N:0]   grp_g;
   logic         c_out_p1_d, c_out_p1_q, vld_p1_d, vld_p1_q;

   always_comb begin
      g_bit      = a_op & b_op;
      p_bit      = a_op ^ b_op;
      grp_g      = sklansky_prefix({g_bit, cin_op}, {p_bit, 1'b0});
      s_p1_d     = p_bit ^ grp_g[N-1:0];
      c_out_p1_d = grp_g[N];
      vld_p1_d   = vld_op;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s_p1_q     <= '0;
         c_out_p1_q <= 1'b0;
         vld_p1_q   <= 1'b0;
      end else begin
         s_p1_q     <= s_p1_d;
         c_out_p1_q <= c_out_p1_d;
         vld_p1_q   <= vld_p1_d;
      end
   end

   assign S         = s_p1_q;
   assign c_out     = c_out_p1_q;
   assign valid_out = vld_p1_q;

endmodule

// File: tb/tb_sklansky_adder.sv
// Scoreboard bench for sklansky_adder at widths 64, 13 and 1 driven in lockstep.
module tb_sklansky_adder;

`ifdef SKLANSKY_ADDER_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk, rst, cin, vin;
   logic [63:0] a64, b64, s64;
   logic [12:0] a13, b13, s13;
   logic        a1, b1, s1;
   logic        c64, c13, c1, v64, v13, v1;

   int n_chk = 0;
   int n_err = 0;
   int edge_cnt = 0;

   typedef struct {
      int          due;
      logic        vld;
      logic [64:0] e64;
      logic [13:0] e13;
      logic [1:0]  e1;
   } item_t;
   item_t q[$];

   sklansky_adder #(.INPUT_SIZE(64)) dut64 (
      .clock(clk), .reset(rst), .A(a64), .B(b64), .c_in(cin), .valid_in(vin),
      .S(s64), .c_out(c64), .valid_out(v64));
   sklansky_adder #(.INPUT_SIZE(13)) dut13 (
      .clock(clk), .reset(rst), .A(a13), .B(b13), .c_in(cin), .valid_in(vin),
      .S(s13), .c_out(c13), .valid_out(v13));
   sklansky_adder #(.INPUT_SIZE(1)) dut1 (
      .clock(clk), .reset(rst), .A(a1), .B(b1), .c_in(cin), .valid_in(vin),
      .S(s1), .c_out(c1), .valid_out(v1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input bit ok, input logic [64:0] act, input logic [64:0] req);
      n_chk++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Sets inputs for the next rising edge and queues the expected results.
   task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic vi,
                        input logic [64:0] e64, input logic [12:0] x13, input logic [12:0] y13,
                        input logic x1, input logic y1);
      item_t it;
      a64 = a; b64 = b; cin = ci; vin = vi;
      a13 = x13; b13 = y13; a1 = x1; b1 = y1;
      it.due = edge_cnt + LAT;
      it.vld = vi;
      it.e64 = e64;
      it.e13 = 14'(x13) + 14'(y13) + 14'(ci);
      it.e1  = 2'(x1) + 2'(y1) + 2'(ci);
      q.push_back(it);
   endtask

   task automatic dv(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic vi,
                     input logic [64:0] e64);
      @(negedge clk); #1;
      apply(a, b, ci, vi, e64, a[12:0], b[12:0], a[0], b[0]);
   endtask

   task automatic dm(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic vi,
                     input logic [12:0] x13, input logic [12:0] y13, input logic x1, input logic y1);
      @(negedge clk); #1;
      apply(a, b, ci, vi, {1'b0, a} + {1'b0, b} + 65'(ci), x13, y13, x1, y1);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk); #1;
      rst = 1'b1;
      vin = 1'b1;
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; cin = 1'b1;
      q.delete();
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk); #1;
         chk("rst_sum64", {c64, s64} === 65'd0, {c64, s64}, 65'd0);
         chk("rst_valid", {v64, v13, v1} === 3'b000, 65'({v64, v13, v1}), 65'd0);
         chk("rst_small", {c13, s13, c1, s1} === 16'd0, 65'({c13, s13, c1, s1}), 65'd0);
      end
      rst = 1'b0;
      apply(64'd0, 64'd0, 1'b0, 1'b0, 65'd0, 13'd0, 13'd0, 1'b0, 1'b0);
   endtask

   // Monitor: every cycle the DUT presents S/c_out; pop the entry due now and compare.
   always @(negedge clk) begin
      item_t it;
      if (!rst) begin
         if (q.size() != 0 && q[0].due <= edge_cnt) begin
            it = q.pop_front();
            chk("latency", it.due == edge_cnt, 65'(edge_cnt), 65'(it.due));
            chk("valid", {v64, v13, v1} === {3{it.vld}}, 65'({v64, v13, v1}), 65'({3{it.vld}}));
            chk("sum64", {c64, s64} === it.e64, {c64, s64}, it.e64);
            chk("sum13", {c13, s13} === it.e13, 65'({c13, s13}), 65'(it.e13));
            chk("sum1", {c1, s1} === it.e1, 65'({c1, s1}), 65'(it.e1));
         end else if (v64 === 1'b1) begin
            chk("spurious_valid", 1'b0, 65'(v64), 65'd0);
         end
      end
   end

   initial begin
      logic [63:0] ra, rb;
      logic [2:0]  k3;
      rst = 1'b1; vin = 1'b0; cin = 1'b0;
      a64 = '0; b64 = '0; a13 = '0; b13 = '0; a1 = 1'b0; b1 = 1'b0;
      do_reset(3);

      // Hand-computed 64-bit vectors.
      dv(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
      dv(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1, 1'b1, {1'b1, 64'h0});
      dv(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, {1'b1, 64'h0});
      dv(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, {1'b1, 64'h0});
      dv(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1, {1'b0, 64'h0000_0001_0000_0000});
      dv(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
      dv(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, {1'b0, 64'h8000_0000_0000_0000});
      dv(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b1, 1'b1, {1'b1, 64'h3});
      dv(64'h5, 64'h7, 1'b0, 1'b0, {1'b0, 64'hC});
      dv(64'h1, 64'h1, 1'b1, 1'b1, {1'b0, 64'h3});

      // Exhaustive 1-bit operands and carry-in.
      for (int k = 0; k < 8; k++) begin
         k3 = 3'(k);
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         dm(ra, rb, k3[2], 1'b1, 13'($urandom), 13'($urandom), k3[0], k3[1]);
      end

      // Random stream with a one-cycle reset in the middle.
      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) do_reset(1);
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         dm(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            13'($urandom), 13'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      dv(64'h0, 64'h0, 1'b0, 1'b0, 65'd0);
      repeat (LAT + 2) @(negedge clk);
      #1;
      chk("drain", q.size() == 0, 65'(q.size()), 65'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/sklansky_adder.md
SKLANSKY_ADDER -- requirements
Module: sklansky_adder

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 64, operand width N in bits; legal range 1..128, not restricted to powers of two.
REQ-002 SHALL have port clock  input  1  the single clock; all registers update on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising clock edge.
REQ-004 SHALL have port A  input  N  first operand (unsigned).
REQ-005 SHALL have port B  input  N  second operand (unsigned).
REQ-006 SHALL have port c_in  input  1  carry into bit 0.
REQ-007 SHALL have port valid_in  input  1  A/B/c_in qualifier.
REQ-008 SHALL have port S  output  N  registered sum bits.
REQ-009 SHALL have port c_out  output  1  registered carry out of bit N-1.
REQ-010 SHALL have port valid_out  output  1  marks S/c_out as holding a fresh result.

Function
REQ-011 SHALL compute {c_out,S} = A + B + c_in exactly: S = (A+B+c_in) mod 2^N; c_out = 1 iff A+B+c_in >= 2^N.
REQ-012 SHALL build the carries with an explicit Sklansky (divide-and-conquer) parallel-prefix network: bitwise g_i=A_i&B_i, p_i=A_i^B_i; c_in injected as generate at position -1; ceil(log2(N+1)) prefix levels; at level k, each position whose index bit k is set combines (G,P) with the last position of the preceding 2^k block via G=Gh|(Ph&Gl), P=Ph&Pl.
REQ-013 SHALL form S_i = p_i ^ carry_i, where carry_0 = c_in; c_out = group generate over bits N-1..-1.
REQ-014 SHALL NOT use a behavioural "+" or ripple chain in the datapath; logic depth grows with log2(N).
REQ-015 SHALL support non-power-of-two N by truncating the prefix tree; no padded bits affect S or c_out.
REQ-016 Default latency SHALL be 1 cycle: result of inputs sampled at edge t appears on S/c_out after edge t, with valid_out = valid_in sampled at t.
REQ-017 S and c_out SHALL update every cycle regardless of valid_in (valid is a qualifier only, no stall, no backpressure).
REQ-018 Back-to-back inputs every cycle SHALL yield one result per cycle, in order.

Reset
REQ-019 While reset is high at a rising edge, S SHALL become all zeros, c_out 0, valid_out 0 (and any internal pipeline registers 0).
REQ-020 Reset mid-stream SHALL discard all in-flight results; the first result after deassertion corresponds to inputs sampled on or after the first edge with reset low.
REQ-021 Outputs SHALL be undefined before the first reset edge; no asynchronous behaviour.

Configuration
REQ-022 Macro SKLANSKY_ADDER_INPUT_REG_EN: when defined, A, B, c_in, valid_in SHALL be registered before the prefix network, latency becomes 2 cycles, input registers reset to 0.
REQ-023 When SKLANSKY_ADDER_INPUT_REG_EN is undefined, no input register SHALL exist and latency SHALL be 1 cycle; function is identical in both builds.

Verification
REQ-024 N=64, A=random, B=~A, c_in=0 -> S=all ones, c_out=0; same with c_in=1 -> S=0, c_out=1.
REQ-025 N=64, A=all ones, B=0, c_in=1 -> S=0, c_out=1; A=B=2^63, c_in=0 -> S=0, c_out=1.
REQ-026 N=64, 10000 random A/B (built from 32-bit chunks), both c_in values, one per cycle -> every {c_out,S} matches A+B+c_in at the configured latency, valid_out tracks valid_in; error count 0.
REQ-027 N=13 and N=1 exhaustive/random sweeps -> results match A+B+c_in; N=1, A=1,B=1,c_in=1 -> S=1, c_out=1.
REQ-028 Streaming with reset asserted for one cycle mid-stream -> next edge S=0, c_out=0, valid_out=0; subsequent results correct with no stale data.
REQ-029 Run REQ-024..REQ-028 with and without SKLANSKY_ADDER_INPUT_REG_EN -> latency 2 vs 1 cycles, identical values.
